// File: rtl/sysio_arb.sv
// Two-master round-robin arbiter in front of a single sysio slave.
// One grant at a time: a write (AW+W together) or a read (AR then R).
module sysio_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [AW-1:0]   m0_awaddr,
    input  logic            m0_awvalid,
    output logic            m0_awready,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    input  logic            m0_wvalid,
    output logic            m0_wready,
    input  logic [AW-1:0]   m0_araddr,
    input  logic            m0_arvalid,
    output logic            m0_arready,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_rvalid,
    input  logic            m0_rready,

    input  logic [AW-1:0]   m1_awaddr,
    input  logic            m1_awvalid,
    output logic            m1_awready,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    input  logic            m1_wvalid,
    output logic            m1_wready,
    input  logic [AW-1:0]   m1_araddr,
    input  logic            m1_arvalid,
    output logic            m1_arready,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_rvalid,
    input  logic            m1_rready,

    output logic [AW-1:0]   s_awaddr,
    output logic            s_awvalid,
    input  logic            s_awready,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    output logic            s_wvalid,
    input  logic            s_wready,
    output logic [AW-1:0]   s_araddr,
    output logic            s_arvalid,
    input  logic            s_arready,
    input  logic [DW-1:0]   s_rdata,
    input  logic            s_rvalid,
    output logic            s_rready
);

    typedef enum logic [1:0] {IDLE, WGNT, RGNT, RWAIT} state_t;

    state_t state, state_next;
    logic   owner, owner_next;
    logic   last, last_next;
    logic   wreq0, wreq1, req0, req1, winner;
    logic   r_hs;

    assign wreq0  = m0_awvalid & m0_wvalid;
    assign wreq1  = m1_awvalid & m1_wvalid;
    assign req0   = wreq0 | m0_arvalid;
    assign req1   = wreq1 | m1_arvalid;
    // On a tie the master that did not win last time goes next.
    assign winner = (req0 & req1) ? ~last : req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            owner <= owner_next;
            last  <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last;
        m0_awready = 1'b0;
        m0_wready  = 1'b0;
        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rvalid  = 1'b0;
        s_awaddr   = '0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wvalid   = 1'b0;
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;

        // Read response path stays open from the AR cycle onward.
        if (state == RGNT || state == RWAIT) begin
            s_rready = owner ? m1_rready : m0_rready;
            if (owner) begin
                m1_rdata  = s_rdata;
                m1_rvalid = s_rvalid;
            end else begin
                m0_rdata  = s_rdata;
                m0_rvalid = s_rvalid;
            end
        end
        r_hs = s_rvalid & s_rready;

        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    owner_next = winner;
                    state_next = (winner ? wreq1 : wreq0) ? WGNT : RGNT;
                end
            end
            WGNT: begin
                s_awaddr  = owner ? m1_awaddr  : m0_awaddr;
                s_awvalid = owner ? m1_awvalid : m0_awvalid;
                s_wdata   = owner ? m1_wdata   : m0_wdata;
                s_wstrb   = owner ? m1_wstrb   : m0_wstrb;
                s_wvalid  = owner ? m1_wvalid  : m0_wvalid;
                if (owner) begin
                    m1_awready = s_awready;
                    m1_wready  = s_wready;
                end else begin
                    m0_awready = s_awready;
                    m0_wready  = s_wready;
                end
                if (s_awvalid & s_awready & s_wvalid & s_wready) begin
                    state_next = IDLE;
                    last_next  = owner;
                end
            end
            RGNT: begin
                s_araddr  = owner ? m1_araddr  : m0_araddr;
                s_arvalid = owner ? m1_arvalid : m0_arvalid;
                if (owner) m1_arready = s_arready;
                else       m0_arready = s_arready;
                if (s_arvalid & s_arready) begin
                    // A response already taken alongside AR completes the read.
                    if (r_hs) begin
                        state_next = IDLE;
                        last_next  = owner;
                    end else begin
                        state_next = RWAIT;
                    end
                end
            end
            RWAIT: begin
                if (r_hs) begin
                    state_next = IDLE;
                    last_next  = owner;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sysio_arb.sv
// Directed bench for sysio_arb: writes, reads, round-robin ties, RWAIT hold and reset.
module tb_sysio_arb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   m0_awaddr, m1_awaddr, m0_araddr, m1_araddr;
    logic            m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid;
    logic            m0_awready, m1_awready, m0_wready, m1_wready;
    logic [DW-1:0]   m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [DW/8-1:0] m0_wstrb, m1_wstrb;
    logic            m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic            m0_rvalid, m1_rvalid, m0_rready, m1_rready;
    logic [AW-1:0]   s_awaddr, s_araddr;
    logic            s_awvalid, s_awready, s_wvalid, s_wready;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [DW/8-1:0] s_wstrb;
    logic            s_arvalid, s_arready, s_rvalid, s_rready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sysio_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_masters();
        m0_awaddr = '0; m0_awvalid = 0; m0_wdata = '0; m0_wstrb = '0; m0_wvalid = 0;
        m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
        m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0;
        m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
    endtask

    task automatic do_reset();
        clear_masters();
        s_awready = 1; s_wready = 1; s_arready = 1; s_rvalid = 0; s_rdata = '0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        // single m0 write
        do_reset();
        #1;
        check_eq("rst_s_awvalid", s_awvalid, 0);
        check_eq("rst_m0_awready", m0_awready, 0);
        check_eq("rst_s_rready", s_rready, 0);
        m0_awaddr = 32'h004; m0_wdata = 32'h0000_00A5; m0_wstrb = 4'hF;
        m0_awvalid = 1; m0_wvalid = 1;
        #1;
        check_eq("w1_idle_s_awvalid", s_awvalid, 0);
        check_eq("w1_idle_m0_awready", m0_awready, 0);
        tick();
        check_eq("w1_s_awvalid", s_awvalid, 1);
        check_eq("w1_s_wvalid", s_wvalid, 1);
        check_eq("w1_s_awaddr", s_awaddr, 32'h004);
        check_eq("w1_s_wdata", s_wdata, 32'h0000_00A5);
        check_eq("w1_s_wstrb", s_wstrb, 4'hF);
        check_eq("w1_m0_awready", m0_awready, 1);
        check_eq("w1_m0_wready", m0_wready, 1);
        check_eq("w1_m1_awready", m1_awready, 0);
        check_eq("w1_m1_wready", m1_wready, 0);
        check_eq("w1_s_arvalid", s_arvalid, 0);
        tick();
        clear_masters();
        #1;
        check_eq("w1_back_idle", s_awvalid, 0);

        // m0 read vs m1 write after reset: m0 first
        do_reset();
        m0_araddr = 32'h100; m0_arvalid = 1;
        m1_awaddr = 32'h104; m1_wdata = 32'hDEAD_0001; m1_wstrb = 4'h3;
        m1_awvalid = 1; m1_wvalid = 1;
        #1;
        check_eq("tie_idle_s_arvalid", s_arvalid, 0);
        tick();
        check_eq("tie_s_arvalid", s_arvalid, 1);
        check_eq("tie_s_araddr", s_araddr, 32'h100);
        check_eq("tie_m0_arready", m0_arready, 1);
        check_eq("tie_m1_awready", m1_awready, 0);
        check_eq("tie_s_awvalid", s_awvalid, 0);
        tick();
        m0_arvalid = 0;
        #1;
        check_eq("tie_rwait_m1_awready", m1_awready, 0);
        check_eq("tie_rwait_s_awvalid", s_awvalid, 0);
        s_rvalid = 1; s_rdata = 32'h0000_CAFE; m0_rready = 1;
        #1;
        check_eq("tie_m0_rvalid", m0_rvalid, 1);
        check_eq("tie_m0_rdata", m0_rdata, 32'h0000_CAFE);
        check_eq("tie_m1_rvalid", m1_rvalid, 0);
        check_eq("tie_s_rready", s_rready, 1);
        tick();
        s_rvalid = 0; m0_rready = 0;
        #1;
        check_eq("tie_idle2_s_awvalid", s_awvalid, 0);
        tick();
        check_eq("tie_m1_grant_awready", m1_awready, 1);
        check_eq("tie_m1_grant_m0_awready", m0_awready, 0);
        check_eq("tie_m1_s_awaddr", s_awaddr, 32'h104);
        check_eq("tie_m1_s_wdata", s_wdata, 32'hDEAD_0001);
        check_eq("tie_m1_s_wstrb", s_wstrb, 4'h3);
        tick();
        clear_masters();

        // continuous writes from both: alternate 0,1,0,1
        m0_awaddr = 32'h300; m0_wdata = 32'h3; m0_wstrb = 4'hF; m0_awvalid = 1; m0_wvalid = 1;
        m1_awaddr = 32'h310; m1_wdata = 32'h31; m1_wstrb = 4'hF; m1_awvalid = 1; m1_wvalid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("rr%0d_idle", i), s_awvalid, 0);
            tick();
            check_eq($sformatf("rr%0d_m0_awready", i), m0_awready, (i % 2 == 0));
            check_eq($sformatf("rr%0d_m1_awready", i), m1_awready, (i % 2 == 1));
            check_eq($sformatf("rr%0d_s_awaddr", i), s_awaddr, (i % 2 == 0) ? 32'h300 : 32'h310);
            tick();
        end
        clear_masters();

        // m1 read held in RWAIT, m0 write pending
        m1_araddr = 32'h204; m1_arvalid = 1;
        tick();
        check_eq("hold_s_araddr", s_araddr, 32'h204);
        check_eq("hold_m1_arready", m1_arready, 1);
        tick();
        m1_arvalid = 0;
        s_rvalid = 1; s_rdata = 32'h1234_5678; m1_rready = 0;
        m0_awaddr = 32'h208; m0_wdata = 32'h77; m0_wstrb = 4'hF; m0_awvalid = 1; m0_wvalid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("hold%0d_m1_rvalid", i), m1_rvalid, 1);
            check_eq($sformatf("hold%0d_m1_rdata", i), m1_rdata, 32'h1234_5678);
            check_eq($sformatf("hold%0d_m0_rdata", i), m0_rdata, 0);
            check_eq($sformatf("hold%0d_s_rready", i), s_rready, 0);
            check_eq($sformatf("hold%0d_m0_awready", i), m0_awready, 0);
            check_eq($sformatf("hold%0d_s_awvalid", i), s_awvalid, 0);
            tick();
        end
        m1_rready = 1;
        #1;
        check_eq("hold_release_s_rready", s_rready, 1);
        tick();
        s_rvalid = 0; m1_rready = 0;
        #1;
        check_eq("hold_idle_s_awvalid", s_awvalid, 0);
        tick();
        check_eq("hold_m0_grant", m0_awready, 1);
        check_eq("hold_m0_s_awaddr", s_awaddr, 32'h208);
        tick();
        clear_masters();

        // reset during RWAIT
        m0_araddr = 32'h400; m0_arvalid = 1;
        tick();
        tick();
        m0_arvalid = 0;
        s_rvalid = 1; s_rdata = 32'hABCD_0000; m0_rready = 0;
        #1;
        check_eq("rstw_pre_m0_rvalid", m0_rvalid, 1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        check_eq("rstw_m0_rvalid", m0_rvalid, 0);
        check_eq("rstw_m0_rdata", m0_rdata, 0);
        check_eq("rstw_s_rready", s_rready, 0);
        check_eq("rstw_s_arvalid", s_arvalid, 0);
        check_eq("rstw_m0_arready", m0_arready, 0);
        s_rvalid = 0;
        m0_araddr = 32'h500; m0_arvalid = 1;
        m1_araddr = 32'h504; m1_arvalid = 1;
        tick();
        check_eq("rstw_tie_m0_arready", m0_arready, 1);
        check_eq("rstw_tie_m1_arready", m1_arready, 0);
        check_eq("rstw_tie_s_araddr", s_araddr, 32'h500);

        // m0 write and read together: write first
        do_reset();
        m0_awaddr = 32'h600; m0_wdata = 32'h66; m0_wstrb = 4'h1; m0_awvalid = 1; m0_wvalid = 1;
        m0_araddr = 32'h604; m0_arvalid = 1;
        tick();
        check_eq("wr_first_s_awvalid", s_awvalid, 1);
        check_eq("wr_first_s_arvalid", s_arvalid, 0);
        check_eq("wr_first_m0_arready", m0_arready, 0);
        tick();
        m0_awvalid = 0; m0_wvalid = 0;
        #1;
        check_eq("wr_first_idle_s_arvalid", s_arvalid, 0);
        tick();
        check_eq("rd_second_s_arvalid", s_arvalid, 1);
        check_eq("rd_second_s_araddr", s_araddr, 32'h604);
        check_eq("rd_second_m0_arready", m0_arready, 1);
        tick();
        m0_arvalid = 0;
        s_rvalid = 1; s_rdata = 32'h55; m0_rready = 1;
        #1;
        check_eq("rd_second_m0_rdata", m0_rdata, 32'h55);
        tick();
        s_rvalid = 0; m0_rready = 0;
        #1;
        check_eq("rd_second_done", s_rready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
